// File: rtl/chess_pkg.sv
// Shared types for the chess board writer: piece/square encodings, colour helpers,
// and the move executor state encoding.
package chess_pkg;

    typedef logic [3:0] piece_t;
    typedef logic [5:0] square_t;

    localparam piece_t EMPTY    = 4'h0;
    localparam piece_t W_PAWN   = 4'h1;
    localparam piece_t W_BISHOP = 4'h2;
    localparam piece_t W_KNIGHT = 4'h3;
    localparam piece_t W_ROOK   = 4'h4;
    localparam piece_t W_QUEEN  = 4'h5;
    localparam piece_t W_KING   = 4'h6;
    localparam piece_t B_PAWN   = 4'h7;
    localparam piece_t B_BISHOP = 4'h8;
    localparam piece_t B_KNIGHT = 4'h9;
    localparam piece_t B_ROOK   = 4'hA;
    localparam piece_t B_QUEEN  = 4'hB;
    localparam piece_t B_KING   = 4'hC;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_SRC,
        ST_RD_DST,
        ST_REM_SRC,
        ST_PLC_DST,
        ST_ROOK_REM,
        ST_ROOK_PLC,
        ST_DONE,
        ST_ERR
    } exec_state_t;

    function automatic logic [2:0] row(input square_t s);
        return s[5:3];
    endfunction

    function automatic logic [2:0] col(input square_t s);
        return s[2:0];
    endfunction

    function automatic logic is_white(input piece_t p);
        return (p >= W_PAWN) && (p <= W_KING);
    endfunction

    function automatic logic is_black(input piece_t p);
        return (p >= B_PAWN) && (p <= B_KING);
    endfunction

    function automatic logic is_valid(input piece_t p);
        return p <= B_KING;
    endfunction

    function automatic logic same_colour(input piece_t a, input piece_t b);
        return (is_white(a) && is_white(b)) || (is_black(a) && is_black(b));
    endfunction

endpackage

// File: rtl/chess_move_executor.sv
// Turns one (from, to) move request into single-cycle remove/place commands on the
// board write port, with capture reporting, pawn promotion and castling.
module chess_move_executor
    import chess_pkg::*;
#(
    parameter bit PROMO_EN  = 1'b1,
    parameter bit CASTLE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [5:0] i_req_from,
    input  logic [5:0] i_req_to,
    output logic [5:0] o_rd_pos,
    input  logic [3:0] i_rd_code,
    output logic [3:0] o_figure_code,
    output logic [5:0] o_figure_position,
    output logic       o_place_piece,
    output logic       o_remove_piece,
    output logic       o_done,
    output logic       o_error,
    output logic [3:0] o_captured_code,
    output logic       o_promoted,
    output logic       o_castled
);

    exec_state_t r_state, r_state_next;
    square_t     r_from, r_from_next;
    square_t     r_to, r_to_next;
    piece_t      r_src, r_src_next;
    piece_t      r_captured, r_captured_next;
    logic        r_promoted, r_promoted_next;
    logic        r_castled, r_castled_next;
    square_t     r_rd_pos, r_rd_pos_next;
    logic        r_place, r_place_next;
    logic        r_remove, r_remove_next;
    square_t     r_fig_pos, r_fig_pos_next;
    piece_t      r_fig_code, r_fig_code_next;
    logic        r_done, r_done_next;
    logic        r_error, r_error_next;

    logic [2:0]        w_from_row, w_from_col, w_to_row, w_to_col;
    logic signed [3:0] w_col_diff;
    logic              w_castle_left;
    logic              w_is_castle;
    logic              w_promote;
    logic              w_reject;
    logic [2:0]        w_rook_to_col;
    square_t           w_rook_from, w_rook_to;
    piece_t            w_rook_code, w_place_code;

    assign w_from_row = row(r_from);
    assign w_from_col = col(r_from);
    assign w_to_row   = row(r_to);
    assign w_to_col   = col(r_to);

    // Signed 4-bit difference so a 3-bit column wrap can never look like a 2-column king step
    assign w_col_diff    = $signed({1'b0, w_to_col}) - $signed({1'b0, w_from_col});
    assign w_castle_left = (w_to_col < w_from_col);
    assign w_is_castle   = CASTLE_EN
                         && ((r_src == W_KING) || (r_src == B_KING))
                         && (w_from_row == w_to_row)
                         && ((w_col_diff == 4'sd2) || (w_col_diff == -4'sd2));

    assign w_rook_to_col = w_castle_left ? (w_to_col + 3'd1) : (w_to_col - 3'd1);
    assign w_rook_from   = {w_from_row, (w_castle_left ? 3'd0 : 3'd7)};
    assign w_rook_to     = {w_from_row, w_rook_to_col};
    assign w_rook_code   = is_white(r_src) ? W_ROOK : B_ROOK;

    assign w_promote    = PROMO_EN
                        && (((r_src == W_PAWN) && (w_to_row == 3'd0))
                         || ((r_src == B_PAWN) && (w_to_row == 3'd7)));
    assign w_place_code = w_promote ? ((r_src == W_PAWN) ? W_QUEEN : B_QUEEN) : r_src;

    // Evaluated in RD_DST, where i_rd_code is the destination contents
    assign w_reject = (r_src == EMPTY) || !is_valid(r_src) || (r_from == r_to)
                    || same_colour(r_src, i_rd_code);

    always_comb begin
        r_state_next    = r_state;
        r_from_next     = r_from;
        r_to_next       = r_to;
        r_src_next      = r_src;
        r_captured_next = r_captured;
        r_promoted_next = r_promoted;
        r_castled_next  = r_castled;
        r_rd_pos_next   = r_rd_pos;
        r_place_next    = 1'b0;
        r_remove_next   = 1'b0;
        r_fig_pos_next  = '0;
        r_fig_code_next = EMPTY;
        r_done_next     = 1'b0;
        r_error_next    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_req_valid) begin
                    r_from_next     = i_req_from;
                    r_to_next       = i_req_to;
                    r_rd_pos_next   = i_req_from;
                    r_captured_next = EMPTY;
                    r_promoted_next = 1'b0;
                    r_castled_next  = 1'b0;
                    r_state_next    = ST_RD_SRC;
                end
            end
            ST_RD_SRC: begin
                r_src_next    = i_rd_code;
                r_rd_pos_next = r_to;
                r_state_next  = ST_RD_DST;
            end
            ST_RD_DST: begin
                r_captured_next = i_rd_code;
                if (w_reject) begin
                    r_error_next = 1'b1;
                    r_state_next = ST_ERR;
                end else begin
                    r_promoted_next = w_promote;
                    r_castled_next  = w_is_castle;
                    r_remove_next   = 1'b1;
                    r_fig_pos_next  = r_from;
                    r_state_next    = ST_REM_SRC;
                end
            end
            ST_REM_SRC: begin
                r_place_next    = 1'b1;
                r_fig_pos_next  = r_to;
                r_fig_code_next = w_place_code;
                r_state_next    = ST_PLC_DST;
            end
            ST_PLC_DST: begin
                if (r_castled) begin
                    r_remove_next  = 1'b1;
                    r_fig_pos_next = w_rook_from;
                    r_state_next   = ST_ROOK_REM;
                end else begin
                    r_done_next  = 1'b1;
                    r_state_next = ST_DONE;
                end
            end
            ST_ROOK_REM: begin
                r_place_next    = 1'b1;
                r_fig_pos_next  = w_rook_to;
                r_fig_code_next = w_rook_code;
                r_state_next    = ST_ROOK_PLC;
            end
            ST_ROOK_PLC: begin
                r_done_next  = 1'b1;
                r_state_next = ST_DONE;
            end
            ST_DONE:  r_state_next = ST_IDLE;
            ST_ERR:   r_state_next = ST_IDLE;
            default:  r_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_from     <= '0;
            r_to       <= '0;
            r_src      <= EMPTY;
            r_captured <= EMPTY;
            r_promoted <= 1'b0;
            r_castled  <= 1'b0;
            r_rd_pos   <= '0;
            r_place    <= 1'b0;
            r_remove   <= 1'b0;
            r_fig_pos  <= '0;
            r_fig_code <= EMPTY;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= r_state_next;
            r_from     <= r_from_next;
            r_to       <= r_to_next;
            r_src      <= r_src_next;
            r_captured <= r_captured_next;
            r_promoted <= r_promoted_next;
            r_castled  <= r_castled_next;
            r_rd_pos   <= r_rd_pos_next;
            r_place    <= r_place_next;
            r_remove   <= r_remove_next;
            r_fig_pos  <= r_fig_pos_next;
            r_fig_code <= r_fig_code_next;
            r_done     <= r_done_next;
            r_error    <= r_error_next;
        end
    end

    assign o_req_ready       = (r_state == ST_IDLE);
    assign o_rd_pos          = r_rd_pos;
    assign o_figure_code     = r_fig_code;
    assign o_figure_position = r_fig_pos;
    assign o_place_piece     = r_place;
    assign o_remove_piece    = r_remove;
    assign o_done            = r_done;
    assign o_error           = r_error;
    assign o_captured_code   = r_captured;
    assign o_promoted        = r_promoted;
    assign o_castled         = r_castled;

endmodule

// File: tb/tb_chess_move_executor.sv
// Directed bench for chess_move_executor: behavioural board model driven by the
// write strobes, cycle-by-cycle checks of the strobe/done/error outputs.
module tb_chess_move_executor;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [5:0] req_from, req_to;
    logic [5:0] rd_pos;
    logic [3:0] rd_code;
    logic [3:0] figure_code;
    logic [5:0] figure_position;
    logic       place_piece, remove_piece, done, error_o;
    logic [3:0] captured_code;
    logic       promoted, castled;

    logic       np_valid;
    logic       np_ready;
    logic [5:0] np_from, np_to, np_rd_pos, np_fig_pos;
    logic [3:0] np_rd_code, np_fig_code, np_captured;
    logic       np_place, np_remove, np_done, np_error, np_promoted, np_castled;

    logic [3:0] board [64];
    logic       poke_en;
    logic [5:0] poke_addr;
    logic [3:0] poke_code;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chess_move_executor dut (
        .clk(clk), .rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_from(req_from), .i_req_to(req_to),
        .o_rd_pos(rd_pos), .i_rd_code(rd_code),
        .o_figure_code(figure_code), .o_figure_position(figure_position),
        .o_place_piece(place_piece), .o_remove_piece(remove_piece),
        .o_done(done), .o_error(error_o),
        .o_captured_code(captured_code), .o_promoted(promoted), .o_castled(castled)
    );

    chess_move_executor #(.PROMO_EN(1'b0), .CASTLE_EN(1'b1)) dut_np (
        .clk(clk), .rst(rst),
        .i_req_valid(np_valid), .o_req_ready(np_ready),
        .i_req_from(np_from), .i_req_to(np_to),
        .o_rd_pos(np_rd_pos), .i_rd_code(np_rd_code),
        .o_figure_code(np_fig_code), .o_figure_position(np_fig_pos),
        .o_place_piece(np_place), .o_remove_piece(np_remove),
        .o_done(np_done), .o_error(np_error),
        .o_captured_code(np_captured), .o_promoted(np_promoted), .o_castled(np_castled)
    );

    // Fixed two-square board for the no-promotion instance: white pawn at 8, black rook at 0
    assign np_rd_code = (np_rd_pos == 6'd8) ? 4'h1 : ((np_rd_pos == 6'd0) ? 4'hA : 4'h0);
    assign rd_code    = board[rd_pos];

    function automatic logic [3:0] init_code(input int sq);
        logic [31:0] blk;
        logic [31:0] wht;
        int c;
        blk = 32'hA98CB89A;
        wht = 32'h43265234;
        c   = sq % 8;
        if (sq < 8)   return blk[(7 - c) * 4 +: 4];
        if (sq < 16)  return 4'h7;
        if (sq >= 56) return wht[(7 - c) * 4 +: 4];
        if (sq >= 48) return 4'h1;
        return 4'h0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) board[i] <= init_code(i);
        end else begin
            if (poke_en)      board[poke_addr]       <= poke_code;
            if (remove_piece) board[figure_position] <= 4'h0;
            if (place_piece)  board[figure_position] <= figure_code;
        end
    end

    function automatic logic [13:0] bnd(input logic rem, input logic plc, input logic [5:0] pos,
                                        input logic [3:0] code, input logic d, input logic e);
        return {rem, plc, pos, code, d, e};
    endfunction

    logic [13:0] obs, np_obs;
    assign obs    = {remove_piece, place_piece, figure_position, figure_code, done, error_o};
    assign np_obs = {np_remove, np_place, np_fig_pos, np_fig_code, np_done, np_error};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [13:0] exp);
        chk(tag, {18'd0, obs}, {18'd0, exp});
        @(negedge clk);
    endtask

    task automatic poke(input logic [5:0] a, input logic [3:0] c);
        poke_en = 1'b1; poke_addr = a; poke_code = c;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Called at a negedge in an idle cycle; returns at the negedge of t1
    task automatic issue(input logic [5:0] f, input logic [5:0] t, input logic hold);
        chk("ready_before_req", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_from = f; req_to = t;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
        chk("rd_pos_src", {26'd0, rd_pos}, {26'd0, f});
    endtask

    task automatic plain_move(input logic [5:0] f, input logic [5:0] t, input logic [3:0] code);
        issue(f, t, 1'b0);
        step("t1_quiet", '0);
        chk("rd_pos_dst", {26'd0, rd_pos}, {26'd0, t});
        chk("busy_not_ready", {31'd0, req_ready}, 32'd0);
        step("t2_quiet", '0);
        step("t3_remove_src", bnd(1'b1, 1'b0, f, 4'h0, 1'b0, 1'b0));
        step("t4_place_dst", bnd(1'b0, 1'b1, t, code, 1'b0, 1'b0));
        step("t5_done", bnd(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 1'b0));
        chk("ready_after_done", {31'd0, req_ready}, 32'd1);
        $display("[TB] move %0d->%0d placed %0h captured %0h promoted %0b",
                 f, t, code, captured_code, promoted);
    endtask

    task automatic castle_move(input logic [5:0] f, input logic [5:0] t, input logic [3:0] kc,
                               input logic [5:0] rf, input logic [5:0] rt, input logic [3:0] rc);
        issue(f, t, 1'b0);
        step("c_t1_quiet", '0);
        step("c_t2_quiet", '0);
        step("c_t3_remove_king", bnd(1'b1, 1'b0, f, 4'h0, 1'b0, 1'b0));
        step("c_t4_place_king", bnd(1'b0, 1'b1, t, kc, 1'b0, 1'b0));
        step("c_t5_remove_rook", bnd(1'b1, 1'b0, rf, 4'h0, 1'b0, 1'b0));
        step("c_t6_place_rook", bnd(1'b0, 1'b1, rt, rc, 1'b0, 1'b0));
        step("c_t7_done", bnd(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 1'b0));
        chk("c_castled", {31'd0, castled}, 32'd1);
        $display("[TB] castle %0d->%0d rook %0d->%0d", f, t, rf, rt);
    endtask

    task automatic reject_move(input logic [5:0] f, input logic [5:0] t, input logic [3:0] cap);
        issue(f, t, 1'b0);
        step("r_t1_quiet", '0);
        step("r_t2_quiet", '0);
        step("r_t3_error", bnd(1'b0, 1'b0, 6'd0, 4'h0, 1'b0, 1'b1));
        chk("r_ready_next", {31'd0, req_ready}, 32'd1);
        chk("r_quiet_after", {18'd0, obs}, 32'd0);
        chk("r_captured", {28'd0, captured_code}, {28'd0, cap});
        chk("r_castled_clear", {31'd0, castled}, 32'd0);
        $display("[TB] reject %0d->%0d captured %0h", f, t, captured_code);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_from = '0; req_to = '0;
        np_valid = 1'b0; np_from = '0; np_to = '0;
        poke_en = 1'b0; poke_addr = '0; poke_code = '0;
        repeat (2) @(negedge clk);
        chk("reset_strobes", {18'd0, obs}, 32'd0);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rd_pos", {26'd0, rd_pos}, 32'd0);
        chk("reset_status", {26'd0, captured_code, promoted, castled}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1. plain pawn push
        plain_move(6'd52, 6'd36, 4'h1);
        chk("m1_captured", {28'd0, captured_code}, 32'd0);
        chk("m1_board", {24'd0, board[52], board[36]}, 32'h01);

        // 2. capture of a black pawn
        poke(6'd27, 4'h7);
        plain_move(6'd36, 6'd27, 4'h1);
        chk("m2_captured", {28'd0, captured_code}, 32'h7);
        chk("m2_board", {24'd0, board[36], board[27]}, 32'h01);

        // 3. white promotion capturing a rook, then black promotion capturing a rook
        poke(6'd8, 4'h1);
        plain_move(6'd8, 6'd0, 4'h5);
        chk("m3_promoted", {31'd0, promoted}, 32'd1);
        chk("m3_captured", {28'd0, captured_code}, 32'hA);
        chk("m3_board", {28'd0, board[0]}, 32'h5);
        poke(6'd48, 4'h7);
        plain_move(6'd48, 6'd56, 4'hB);
        chk("m3b_promoted", {31'd0, promoted}, 32'd1);
        chk("m3b_captured", {28'd0, captured_code}, 32'h4);

        // 3c. same pawn move on the PROMO_EN=0 instance places the pawn unchanged
        np_valid = 1'b1; np_from = 6'd8; np_to = 6'd0;
        @(negedge clk);
        np_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("np_t3_remove", {18'd0, np_obs}, {18'd0, bnd(1'b1, 1'b0, 6'd8, 4'h0, 1'b0, 1'b0)});
        @(negedge clk);
        chk("np_t4_place", {18'd0, np_obs}, {18'd0, bnd(1'b0, 1'b1, 6'd0, 4'h1, 1'b0, 1'b0)});
        @(negedge clk);
        chk("np_t5_done", {18'd0, np_obs}, {18'd0, bnd(1'b0, 1'b0, 6'd0, 4'h0, 1'b1, 1'b0)});
        chk("np_status", {26'd0, np_captured, np_promoted, np_castled}, 32'h28);
        $display("[TB] no-promo move 8->0 placed %0h", 4'h1);
        @(negedge clk);

        // 4. white queenside-style castle (king col 3 -> 1), then black king col 3 -> 5
        poke(6'd57, 4'h0);
        poke(6'd58, 4'h0);
        castle_move(6'd59, 6'd57, 4'h6, 6'd56, 6'd58, 4'h4);
        chk("c1_board", {16'd0, board[56], board[57], board[58], board[59]}, 32'h0640);
        chk("c1_captured", {28'd0, captured_code}, 32'd0);
        poke(6'd4, 4'h0);
        poke(6'd5, 4'h0);
        castle_move(6'd3, 6'd5, 4'hC, 6'd7, 6'd4, 4'hA);
        chk("c2_board", {16'd0, board[3], board[4], board[5], board[7]}, 32'h0AC0);

        // 5. rejections: empty source, own-colour destination, from==to, invalid code
        reject_move(6'd40, 6'd32, 4'h0);
        poke(6'd59, 4'h6);
        reject_move(6'd59, 6'd60, 4'h5);
        chk("r_board_intact", {24'd0, board[59], board[60]}, 32'h65);
        reject_move(6'd60, 6'd60, 4'h5);
        poke(6'd41, 4'hD);
        reject_move(6'd41, 6'd33, 4'h0);

        // 6. async reset at t4 of a castle with req_valid held high while busy
        issue(6'd5, 6'd3, 1'b1);
        step("x_t1_quiet", '0);
        chk("x_busy_not_ready", {31'd0, req_ready}, 32'd0);
        step("x_t2_quiet", '0);
        step("x_t3_remove_king", bnd(1'b1, 1'b0, 6'd5, 4'h0, 1'b0, 1'b0));
        chk("x_t4_place_king", {18'd0, obs}, {18'd0, bnd(1'b0, 1'b1, 6'd3, 4'hC, 1'b0, 1'b0)});
        rst = 1'b1;
        #1;
        chk("x_rst_strobes", {18'd0, obs}, 32'd0);
        chk("x_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("x_rst_status", {20'd0, rd_pos, captured_code, promoted, castled}, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("x_no_accept_pos", {26'd0, rd_pos}, 32'd0);
        step("x_quiet_1", '0);
        step("x_quiet_2", '0);
        chk("x_idle_ready", {31'd0, req_ready}, 32'd1);
        $display("[TB] reset during castle handled");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
